// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter sharing one memory port between fetch and load/store
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ifu_reqValid,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_respValid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_reqValid,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_respValid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_reqValid,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_respValid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                is_busy
);

  localparam int MASK_W = DATA_W / 8;

  typedef enum logic {S_IDLE, S_WAIT} state_t;
  typedef enum logic {REQ_IFU, REQ_LSU} req_t;

  state_t              state;
  req_t                owner;
  req_t                last_grant;
  req_t                winner;
  logic                pend_ifu;
  logic                pend_lsu;
  logic [ADDR_W-1:0]   ifu_addr_q;
  logic [ADDR_W-1:0]   lsu_addr_q;
  logic                lsu_wen_q;
  logic [DATA_W-1:0]   lsu_wdata_q;
  logic [MASK_W-1:0]   lsu_wmask_q;
  logic                issue;
  logic                resp;
  logic                ifu_resp;
  logic                lsu_resp;

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    winner = REQ_IFU;
    if (pend_ifu && pend_lsu) begin
      winner = (last_grant == REQ_LSU) ? REQ_IFU : REQ_LSU;
    end else if (pend_lsu) begin
      winner = REQ_LSU;
    end
  end

  assign issue    = (state == S_IDLE) && (pend_ifu || pend_lsu);
  assign resp     = (state == S_WAIT) && mem_respValid;
  assign ifu_resp = resp && (owner == REQ_IFU);
  assign lsu_resp = resp && (owner == REQ_LSU);

  assign mem_reqValid  = issue;
  assign ifu_respValid = ifu_resp;
  assign lsu_respValid = lsu_resp;
  assign ifu_rdata     = mem_rdata;
  assign lsu_rdata     = mem_rdata;
  assign is_busy       = (state != S_IDLE) || pend_ifu || pend_lsu;

  always_comb begin
    mem_addr  = '0;
    mem_wen   = 1'b0;
    mem_wdata = '0;
    mem_wmask = '0;
    if (issue) begin
      if (winner == REQ_LSU) begin
        mem_addr  = lsu_addr_q;
        mem_wen   = lsu_wen_q;
        mem_wdata = lsu_wdata_q;
        mem_wmask = lsu_wmask_q;
      end else begin
        mem_addr  = ifu_addr_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      owner       <= REQ_IFU;
      last_grant  <= REQ_LSU;
      pend_ifu    <= 1'b0;
      pend_lsu    <= 1'b0;
      ifu_addr_q  <= '0;
      lsu_addr_q  <= '0;
      lsu_wen_q   <= 1'b0;
      lsu_wdata_q <= '0;
      lsu_wmask_q <= '0;
    end else begin
      // A new capture from the owner in its response cycle wins over the clear.
      if (ifu_reqValid && (!pend_ifu || ifu_resp)) begin
        pend_ifu   <= 1'b1;
        ifu_addr_q <= ifu_addr;
      end else if (ifu_resp) begin
        pend_ifu   <= 1'b0;
      end

      if (lsu_reqValid && (!pend_lsu || lsu_resp)) begin
        pend_lsu    <= 1'b1;
        lsu_addr_q  <= lsu_addr;
        lsu_wen_q   <= lsu_wen;
        lsu_wdata_q <= lsu_wdata;
        lsu_wmask_q <= lsu_wmask;
      end else if (lsu_resp) begin
        pend_lsu    <= 1'b0;
      end

      if (state == S_IDLE) begin
        if (issue) begin
          owner <= winner;
          state <= S_WAIT;
        end
      end else begin
        if (mem_respValid) begin
          last_grant <= owner;
          state      <= S_IDLE;
        end
      end
    end
  end

endmodule
